// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, TX state type
// and frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Serial bits in one frame: start + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Shared between the TX and RX sides.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (data width, parity, stop bits, baud divider).
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  import uart_pkg::*;

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end

  localparam int CNT_W = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS));
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY == PAR_ODD);
  localparam logic HAS_PAR = (PARITY != PAR_NONE);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 bit_end;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;

  assign tx_busy = (state != IDLE);
  assign tx_done = (state == STOP) && (bit_cnt == LAST_STOP) && bit_end;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == IDLE) || load),
    .bit_end(bit_end)
  );

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;

  // Extra pointer MSB tells a full FIFO from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_ready = !full;
  assign push     = tx_start && tx_ready;
  // Popping during tx_done lets the next frame follow with no idle gap.
  assign load      = !empty && ((state == IDLE) || tx_done);
  assign load_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
`else
  assign tx_ready  = !tx_busy;
  assign load      = tx_start && tx_ready;
  assign load_data = tx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (load) begin
            shreg   <= load_data;
            par_q   <= (^load_data) ^ PAR_INV;
            bit_cnt <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (HAS_PAR) begin
                tx    <= par_q;
                state <= uart_pkg::PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (load) begin
                shreg <= load_data;
                par_q <= (^load_data) ^ PAR_INV;
                tx    <= 1'b0;
                state <= START;
              end else begin
                tx    <= 1'b1;
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at 16 clocks
// per bit, each frame compared against a serial-frame model built from data.
module tb_uart_tx_param;

  localparam int CPB = 16;
  localparam int DB_C  [4] = '{8, 8, 8, 7};
  localparam int PAR_C [4] = '{0, 2, 1, 0};
  localparam int SB_C  [4] = '{1, 1, 1, 2};
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] start_v;
  logic [8:0] data_v [4];
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  wire  [3:0] done_v;
  wire  [3:0] ready_v;

  int checks;
  int errors;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .tx_start(start_v[0]), .tx_data(data_v[0][7:0]),
    .tx_ready(ready_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx(tx_v[0]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .tx_start(start_v[1]), .tx_data(data_v[1][7:0]),
    .tx_ready(ready_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx(tx_v[1]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .tx_start(start_v[2]), .tx_data(data_v[2][7:0]),
    .tx_ready(ready_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx(tx_v[2]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .rst(rst), .tx_start(start_v[3]), .tx_data(data_v[3][6:0]),
    .tx_ready(ready_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx(tx_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial bits of one frame for instance k, in line order.
  task automatic build_frame(input int k, input int d, output int bits [16], output int len);
    int ones;
    int pos;
    bits[0] = 0;
    for (int i = 0; i < DB_C[k]; i++) bits[1 + i] = (d >> i) & 1;
    pos = 1 + DB_C[k];
    ones = $countones(d & ((1 << DB_C[k]) - 1));
    if (PAR_C[k] == 2) begin
      bits[pos] = ones % 2;
      pos++;
    end else if (PAR_C[k] == 1) begin
      bits[pos] = 1 - (ones % 2);
      pos++;
    end
    for (int s = 0; s < SB_C[k]; s++) begin
      bits[pos] = 1;
      pos++;
    end
    len = pos;
  endtask

  // Request one frame on instance k and check the whole line waveform.
  // inj >= 0 fires a second request (data 0xAA) at that capture cycle.
  task automatic run_frame(input int k, input int d, input int inj, input string name);
    int bits [16];
    int len, off, n, mism, bad, done_n, done_at, rdy_bad;
    bit exp_b;
    logic [255:0] cap_tx, cap_busy, cap_done, cap_ready;
    build_frame(k, d, bits, len);
    off = LAT - 1;
    n = len * CPB + 20;
    @(negedge clk);
    start_v[k] = 1'b1;
    data_v[k]  = 9'(d);
    @(negedge clk);
    start_v[k] = 1'b0;
    data_v[k]  = 9'($urandom_range(0, 511));
    for (int c = 0; c < n; c++) begin
      cap_tx[c]    = tx_v[k];
      cap_busy[c]  = busy_v[k];
      cap_done[c]  = done_v[k];
      cap_ready[c] = ready_v[k];
      if (c == inj) begin
        start_v[k] = 1'b1;
        data_v[k]  = 9'h0AA;
      end else if (c == inj + 1) begin
        start_v[k] = 1'b0;
      end
      @(negedge clk);
    end
    for (int b = 0; b < len; b++) begin
      mism = 0;
      for (int j = 0; j < CPB; j++)
        if (cap_tx[off + b * CPB + j] !== 1'(bits[b])) mism++;
      checks++;
      if (mism != 0) begin
        errors++;
        $display("FAIL %s bit%0d: %0d of %0d cycles wrong, required level %0d", name, b, mism, CPB, bits[b]);
      end
    end
    bad = 0; done_n = 0; done_at = -1; rdy_bad = 0; mism = 0;
    for (int c = 0; c < n; c++) begin
      exp_b = (c >= off) && (c < off + len * CPB);
      if (cap_busy[c] !== exp_b) bad++;
      if (!exp_b && cap_tx[c] !== 1'b1) mism++;
      if (cap_ready[c] !== !exp_b) rdy_bad++;
      if (cap_done[c] === 1'b1) begin
        if (done_at < 0) done_at = c;
        done_n++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s busy: %0d cycles differ, required high for %0d cycles", name, bad, len * CPB);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL %s idle_line: %0d idle cycles not high, required 0", name, mism);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d pulses, required 1", name, done_n);
    end
    checks++;
    if (done_at != off + len * CPB - 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d, required %0d", name, done_at, off + len * CPB - 1);
    end
`ifndef UART_TX_FIFO_EN
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL %s ready: %0d cycles with ready != !busy_expected, required 0", name, rdy_bad);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '0;
    for (int k = 0; k < 4; k++) data_v[k] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_v !== 4'hF) begin errors++; $display("FAIL reset_tx: got %b, required 1111", tx_v); end
    checks++;
    if (busy_v !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b, required 0000", busy_v); end
    checks++;
    if (done_v !== 4'h0) begin errors++; $display("FAIL reset_done: got %b, required 0000", done_v); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_v !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b, required 1111", ready_v); end
  endtask

  task automatic test_single_frame();
    run_frame(0, 'h41, -1, "8n1_0x41");
  endtask

  task automatic test_parity();
    run_frame(1, 'h41, -1, "even_0x41");
    run_frame(2, 'h41, -1, "odd_0x41");
    run_frame(1, 'h07, -1, "even_0x07");
  endtask

  task automatic test_seven_two();
    run_frame(3, 'h55, -1, "7n2_0x55");
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_busy_ignore();
    run_frame(0, 'h41, 39, "busy_ignore");
  endtask
`endif

  task automatic test_reset_mid_frame();
    int bad;
    @(negedge clk);
    start_v[0] = 1'b1;
    data_v[0]  = 9'h041;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b, required 1", busy_v[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_v[0] !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b, required 1", tx_v[0]); end
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy_v[0]); end
    checks++;
    if (done_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b, required 0", done_v[0]); end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_quiet: %0d active cycles after abort, required 0", bad); end
    run_frame(0, 'h41, -1, "after_reset");
  endtask

  task automatic test_random();
    int k;
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, 3);
      run_frame(k, $urandom_range(0, 511), -1, $sformatf("random%0d_inst%0d", r, k));
    end
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo_burst();
    int vals [5];
    int stream [50];
    int bits [16];
    int len, exp_tx, tx_bad, busy_bad, done_bad, done_n, rdy_bad, push_bad;
    bit exp_busy;
    vals = '{'h11, 'h22, 'h33, 'h44, 'h55};
    for (int f = 0; f < 5; f++) begin
      build_frame(0, vals[f], bits, len);
      for (int b = 0; b < 10; b++) stream[f * 10 + b] = bits[b];
    end
    tx_bad = 0; busy_bad = 0; done_bad = 0; done_n = 0; rdy_bad = 0; push_bad = 0;
    @(negedge clk);
    if (ready_v[0] !== 1'b1) push_bad++;
    start_v[0] = 1'b1;
    data_v[0]  = 9'(vals[0]);
    for (int t = 0; t < 5 * 10 * CPB + 20; t++) begin
      @(negedge clk);
      exp_busy = (t >= 1) && (t < 1 + 50 * CPB);
      exp_tx = exp_busy ? stream[(t - 1) / CPB] : 1;
      if (tx_v[0] !== 1'(exp_tx)) tx_bad++;
      if (busy_v[0] !== exp_busy) busy_bad++;
      if (done_v[0] === 1'b1) done_n++;
      if (done_v[0] !== ((t > 0) && (t % (10 * CPB) == 0) && (t <= 50 * CPB))) done_bad++;
      if (t >= 4 && t <= 10 * CPB && ready_v[0] !== 1'b0) rdy_bad++;
      if (t == 10 * CPB + 1 && ready_v[0] !== 1'b1) rdy_bad++;
      if (t < 4) begin
        if (ready_v[0] !== 1'b1) push_bad++;
        data_v[0] = 9'(vals[t + 1]);
      end else if (t == 4) begin
        start_v[0] = 1'b0;
      end
    end
    checks++;
    if (push_bad != 0) begin errors++; $display("FAIL fifo_push_ready: %0d pushes saw ready low, required 0", push_bad); end
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL fifo_full_ready: %0d cycles wrong, required 0", rdy_bad); end
    checks++;
    if (tx_bad != 0) begin errors++; $display("FAIL fifo_tx_stream: %0d cycles wrong, required 0", tx_bad); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL fifo_busy: %0d cycles wrong, required 0", busy_bad); end
    checks++;
    if (done_n != 5) begin errors++; $display("FAIL fifo_done_count: got %0d, required 5", done_n); end
    checks++;
    if (done_bad != 0) begin errors++; $display("FAIL fifo_done_cycles: %0d cycles wrong, required 0", done_bad); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_parity();
    test_seven_two();
`ifndef UART_TX_FIFO_EN
    test_busy_ignore();
`endif
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_FIFO_EN
    test_fifo_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
